// File: rtl/id_stage.sv
// MIPS-subset instruction decode stage with a one-entry ID/EX register.
// Uses a valid/ready handshake on both sides; flush discards the held entry and any incoming one.
module id_stage (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] instr,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  input  logic        flush,
  input  logic        out_ready,
  output logic        out_valid,
  output logic [2:0]  aluc,
  output logic [31:0] op_a,
  output logic [31:0] op_b,
  output logic [31:0] st_data,
  output logic [4:0]  rd_dst,
  output logic        reg_write,
  output logic        mem_read,
  output logic        mem_write,
  output logic        mem_to_reg,
  output logic        branch,
  output logic        illegal
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;

  localparam logic [5:0] FN_ADD   = 6'b100000;
  localparam logic [5:0] FN_ADDU  = 6'b100001;
  localparam logic [5:0] FN_SUB   = 6'b100010;
  localparam logic [5:0] FN_SUBU  = 6'b100011;
  localparam logic [5:0] FN_AND   = 6'b100100;
  localparam logic [5:0] FN_OR    = 6'b100101;

  localparam logic [2:0] ALU_ADD  = 3'b000;
  localparam logic [2:0] ALU_SUB  = 3'b001;
  localparam logic [2:0] ALU_OR   = 3'b010;
  localparam logic [2:0] ALU_AND  = 3'b011;

  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic [31:0] imm_zext;
  logic [31:0] imm_sext;
  logic        load;

  logic [2:0]  aluc_next;
  logic [31:0] op_a_next;
  logic [31:0] op_b_next;
  logic [31:0] st_data_next;
  logic [4:0]  rd_dst_next;
  logic        reg_write_dec;
  logic        rtype_ok;
  logic [5:0]  ctrl_next;

  logic        out_valid_reg;
  logic [2:0]  aluc_reg;
  logic [31:0] op_a_reg;
  logic [31:0] op_b_reg;
  logic [31:0] st_data_reg;
  logic [4:0]  rd_dst_reg;
  // Control bits packed as {reg_write, mem_read, mem_write, mem_to_reg, branch, illegal}
  logic [5:0]  ctrl_reg;

  assign opcode   = instr[31:26];
  assign funct    = instr[5:0];
  assign imm_zext = {16'h0000, instr[15:0]};
  assign imm_sext = {{16{instr[15]}}, instr[15:0]};

  assign in_ready = !out_valid_reg || out_ready;
  assign load     = in_valid && in_ready && !flush;

  always_comb begin
    aluc_next     = ALU_ADD;
    op_a_next     = 32'h0;
    op_b_next     = 32'h0;
    st_data_next  = 32'h0;
    rd_dst_next   = 5'd0;
    reg_write_dec = 1'b0;
    rtype_ok      = 1'b0;
    ctrl_next     = 6'b000000;

    case (opcode)
      OP_RTYPE: begin
        if (instr == 32'h0000_0000) begin
          op_a_next = rs_data;
        end else begin
          rtype_ok = 1'b1;
          case (funct)
            FN_ADD, FN_ADDU: aluc_next = ALU_ADD;
            FN_SUB, FN_SUBU: aluc_next = ALU_SUB;
            FN_AND:          aluc_next = ALU_AND;
            FN_OR:           aluc_next = ALU_OR;
            default:         rtype_ok  = 1'b0;
          endcase
          if (rtype_ok) begin
            op_a_next     = rs_data;
            op_b_next     = rt_data;
            rd_dst_next   = instr[15:11];
            reg_write_dec = 1'b1;
          end else begin
            ctrl_next[0] = 1'b1;
          end
        end
      end
      OP_ORI: begin
        aluc_next     = ALU_OR;
        op_a_next     = rs_data;
        op_b_next     = imm_zext;
        rd_dst_next   = instr[20:16];
        reg_write_dec = 1'b1;
      end
      OP_LW: begin
        op_a_next     = rs_data;
        op_b_next     = imm_sext;
        rd_dst_next   = instr[20:16];
        reg_write_dec = 1'b1;
        ctrl_next[4]  = 1'b1;
        ctrl_next[2]  = 1'b1;
      end
      OP_SW: begin
        op_a_next    = rs_data;
        op_b_next    = imm_sext;
        st_data_next = rt_data;
        ctrl_next[3] = 1'b1;
      end
      OP_BEQ: begin
        aluc_next    = ALU_SUB;
        op_a_next    = rs_data;
        op_b_next    = rt_data;
        ctrl_next[1] = 1'b1;
      end
      default: ctrl_next[0] = 1'b1;
    endcase

    // Writes to $0 are architecturally discarded, so never request them.
    ctrl_next[5] = reg_write_dec && (rd_dst_next != 5'd0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_reg <= 1'b0;
      aluc_reg      <= 3'b000;
      op_a_reg      <= 32'h0;
      op_b_reg      <= 32'h0;
      st_data_reg   <= 32'h0;
      rd_dst_reg    <= 5'd0;
      ctrl_reg      <= 6'b000000;
    end else if (flush) begin
      out_valid_reg <= 1'b0;
      ctrl_reg      <= 6'b000000;
    end else if (load) begin
      out_valid_reg <= 1'b1;
      aluc_reg      <= aluc_next;
      op_a_reg      <= op_a_next;
      op_b_reg      <= op_b_next;
      st_data_reg   <= st_data_next;
      rd_dst_reg    <= rd_dst_next;
      ctrl_reg      <= ctrl_next;
    end else if (out_ready) begin
      out_valid_reg <= 1'b0;
      ctrl_reg      <= 6'b000000;
    end
  end

  assign out_valid  = out_valid_reg;
  assign aluc       = aluc_reg;
  assign op_a       = op_a_reg;
  assign op_b       = op_b_reg;
  assign st_data    = st_data_reg;
  assign rd_dst     = rd_dst_reg;
  assign reg_write  = ctrl_reg[5];
  assign mem_read   = ctrl_reg[4];
  assign mem_write  = ctrl_reg[3];
  assign mem_to_reg = ctrl_reg[2];
  assign branch     = ctrl_reg[1];
  assign illegal    = ctrl_reg[0];

endmodule
